// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants for the seven-segment scan display.
//   SEG_OFF  - all segments / enables dark (active-low outputs)
//   ADDR_LO  - segaddr selecting value[15:0]
//   ADDR_HI  - segaddr selecting value[31:16]
//   HEX_SEG  - active-low {dp,g,f,e,d,c,b,a} pattern per hex nibble, dp off
package seg7_pkg;
  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [1:0] ADDR_LO = 2'b00;
  localparam logic [1:0] ADDR_HI = 2'b10;

  // Entry n is the pattern for nibble n (entry 0 sits in the low byte).
  localparam logic [15:0][7:0] HEX_SEG = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };
endpackage

// File: rtl/seg7_scan_display_hex.sv
// hex_to_seg7: combinational nibble to active-low segment pattern.
//   i_nib - hex digit 0..F
//   o_seg - {dp,g,f,e,d,c,b,a}, active-low, dp always off
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [7:0] o_seg
);
  assign o_seg = HEX_SEG[i_nib];
endmodule

// File: rtl/seg7_scan_display.sv
// seg7_scan_display: memory-mapped 8-digit multiplexed seven-segment driver.
// CPU IO writes load 16-bit halves of a 32-bit value; a prescaler steps a
// digit index every SCAN_DIV clocks and the registered outputs light one
// digit at a time.
//   clock    - CPU clock
//   reset    - async reset, active-low
//   segwrite - IO write strobe
//   segcs    - display chip-select
//   segaddr  - 00 low half, 10 high half, others ignored
//   segwdata - write data
//   ena      - digit enables, active-low, bit i = digit i
//   light    - segments, active-low, [7] = dp
// Optional: define SEG7_BLANK_LEADING_ZERO_EN to blank leading-zero digits
// (digit 0 is always shown).
module seg7_scan_display
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV = 20000,
  parameter int DIGITS   = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              segwrite,
  input  logic              segcs,
  input  logic [1:0]        segaddr,
  input  logic [15:0]       segwdata,
  output logic [DIGITS-1:0] ena,
  output logic [7:0]        light
);
  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(DIGITS);
  localparam logic [PW-1:0] PMAX = PW'(SCAN_DIV - 1);

  logic [4*DIGITS-1:0] r_value;
  logic [PW-1:0]       r_presc;
  logic [IW-1:0]       r_idx;
  logic [DIGITS-1:0]   r_ena;
  logic [7:0]          r_light;

  logic                w_wrap;
  logic [3:0]          w_nib;
  logic [7:0]          w_seg;
  logic [DIGITS-1:0]   w_ena_sel;
  logic                w_blank;

  assign w_wrap    = (r_presc == PMAX);
  assign w_nib     = r_value[{r_idx, 2'b00} +: 4];
  assign w_ena_sel = ~(DIGITS'(1) << r_idx);

`ifdef SEG7_BLANK_LEADING_ZERO_EN
  // Blank when this nibble and every nibble above it are zero.
  assign w_blank = (r_idx != '0) && ((r_value >> {r_idx, 2'b00}) == '0);
`else
  assign w_blank = 1'b0;
`endif

  hex_to_seg7 u_hex (
    .i_nib (w_nib),
    .o_seg (w_seg)
  );

  // Value register, prescaler and digit index.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_value <= '0;
      r_presc <= '0;
      r_idx   <= '0;
    end else begin
      if (segcs && segwrite) begin
        if (segaddr == ADDR_LO)      r_value[15:0]  <= segwdata;
        else if (segaddr == ADDR_HI) r_value[31:16] <= segwdata;
      end
      if (w_wrap) begin
        r_presc <= '0;
        r_idx   <= r_idx + 1'b1;   // DIGITS is a power of two: wraps 7->0
      end else begin
        r_presc <= r_presc + 1'b1;
      end
    end
  end

  // Outputs lag the index/value by one edge, so a write or digit step
  // taking effect on an edge shows up on the following edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_ena   <= '1;
      r_light <= SEG_OFF;
    end else begin
      r_ena   <= w_blank ? '1      : w_ena_sel;
      r_light <= w_blank ? SEG_OFF : w_seg;
    end
  end

  assign ena   = r_ena;
  assign light = r_light;
endmodule

// File: tb/tb_seg7_scan_display.sv
module tb_seg7_scan_display;
  localparam int SD = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        segwrite = 1'b0;
  logic        segcs = 1'b0;
  logic [1:0]  segaddr = 2'b00;
  logic [15:0] segwdata = 16'h0;
  logic [7:0]  ena, light;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  logic [7:0] lit_abcd1234 [8] = '{8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hA1, 8'hC6, 8'h83, 8'h88};

  seg7_scan_display #(.SCAN_DIV(SD), .DIGITS(8)) dut (
    .clock(clock), .reset(reset), .segwrite(segwrite), .segcs(segcs),
    .segaddr(segaddr), .segwdata(segwdata), .ena(ena), .light(light)
  );

  always #5 clock = ~clock;

  // Model: cnt = edges since reset release; digit shown after the next edge
  // is (cnt / SD) % 8, built from the value as it stood before that edge.
  int          m_cnt;
  logic [31:0] m_val;
  logic [7:0]  m_ena, m_light;

  function automatic logic [15:0] model_out(int cnt, logic [31:0] v);
    int d;
    logic [31:0] hi;
    d  = (cnt / SD) % 8;
    hi = v >> (4 * d);
`ifdef SEG7_BLANK_LEADING_ZERO_EN
    if (d != 0 && hi == 0) return 16'hFFFF;
`endif
    return {~(8'h01 << d), seg_tab[hi[3:0]]};
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_cnt <= 0; m_val <= 32'h0; m_ena <= 8'hFF; m_light <= 8'hFF;
    end else begin
      {m_ena, m_light} <= model_out(m_cnt, m_val);
      m_cnt <= m_cnt + 1;
      if (segcs && segwrite) begin
        if (segaddr == 2'b00)      m_val[15:0]  <= segwdata;
        else if (segaddr == 2'b10) m_val[31:16] <= segwdata;
      end
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      checks++;
      if (ena !== m_ena || light !== m_light) begin
        failures++;
        $display("FAIL scan t=%0t ena=%h light=%h expected ena=%h light=%h",
                 $time, ena, light, m_ena, light === m_light ? light : m_light);
      end
`ifndef SEG7_BLANK_LEADING_ZERO_EN
      if (reset && m_cnt != 0) begin
        checks++;
        if ($countones(~ena) != 1) begin
          failures++;
          $display("FAIL onehot t=%0t ena=%h expected exactly one low bit", $time, ena);
        end
      end
`endif
    end
  end

  task automatic check8(string name, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask

  // Return at the first negedge of digit k's slot (after leaving any current one).
  task automatic wait_ena(int k, output bit found);
    logic [7:0] tgt;
    int n;
    tgt = ~(8'h01 << k);
    found = 1'b0;
    n = 0;
    while (ena === tgt && n < 200) begin @(negedge clock); n++; end
    while (ena !== tgt && n < 200) begin @(negedge clock); n++; end
    found = (ena === tgt);
    if (!found) begin
      checks++; failures++;
      $display("FAIL wait_digit%0d timeout ena=%h expected=%h", k, ena, tgt);
    end
  endtask

  task automatic wait_digit(int k, logic [7:0] exp_light);
    bit f;
    wait_ena(k, f);
    if (f) check8($sformatf("digit%0d_light", k), light, exp_light);
  endtask

  task automatic io_write(logic cs, logic [1:0] a, logic [15:0] d);
    @(negedge clock);
    segcs = cs; segwrite = 1'b1; segaddr = a; segwdata = d;
    @(negedge clock);
    segcs = 1'b0; segwrite = 1'b0;
  endtask

  initial begin
    bit f;
    repeat (3) @(negedge clock);
    chk_en = 1'b1;
    check8("rst_ena", ena, 8'hFF);
    check8("rst_light", light, 8'hFF);

    // Release and check the first output edge.
    reset = 1'b1;
    @(negedge clock);
    check8("first_ena", ena, 8'hFE);
    check8("first_light", light, 8'hC0);
`ifndef SEG7_BLANK_LEADING_ZERO_EN
    for (int k = 1; k < 8; k++) wait_digit(k, 8'hC0);
    wait_digit(0, 8'hC0);
`endif
    repeat (10) @(negedge clock);

    // Half writes.
    io_write(1'b1, 2'b00, 16'h1234);
    io_write(1'b1, 2'b10, 16'hABCD);
    for (int k = 0; k < 8; k++) wait_digit(k, lit_abcd1234[k]);

    // Ignored writes: odd address, and strobe without chip-select.
    io_write(1'b1, 2'b01, 16'hFFFF);
    io_write(1'b0, 2'b00, 16'hFFFF);
    wait_digit(0, 8'h99);
    wait_digit(7, 8'h88);
    wait_digit(2, 8'hA4);

    // Write landing on the 7->0 digit-advance edge.
    wait_ena(7, f);
    if (f) begin
      repeat (2) @(negedge clock);
      segcs = 1'b1; segwrite = 1'b1; segaddr = 2'b00; segwdata = 16'h0005;
      @(negedge clock);
      segcs = 1'b0; segwrite = 1'b0;
      check8("adv_pre_ena", ena, 8'h7F);
      @(negedge clock);
      check8("adv_ena", ena, 8'hFE);
      check8("adv_light", light, 8'h92);
    end

    // Reset during digit 5: dark before the next edge.
    wait_ena(5, f);
    @(negedge clock);
    #2 reset = 1'b0;
    #1;
    check8("midrst_ena", ena, 8'hFF);
    check8("midrst_light", light, 8'hFF);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check8("restart_ena", ena, 8'hFE);
    check8("restart_light", light, 8'hC0);
    repeat (40) @(negedge clock);

`ifdef SEG7_BLANK_LEADING_ZERO_EN
    io_write(1'b1, 2'b00, 16'h0040);
    io_write(1'b1, 2'b10, 16'h0000);
    wait_digit(1, 8'h99);
    wait_digit(0, 8'hC0);
    repeat (40) @(negedge clock);
`endif

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
